// File: rtl/indexed_up_packer_if.sv
// Field-in / word-out handshake bundle for indexed_up_packer.
// out_data keeps the caller's [MSB:LSB] range and direction.
interface indexed_up_packer_if #(
    parameter int MSB   = 0,
    parameter int LSB   = 0,
    parameter int CHUNK = 2
);
    localparam int unsigned N  = (MSB > LSB) ? (MSB - LSB + 1) : (LSB - MSB + 1);
    localparam int unsigned BW = $clog2(N + 1);

    logic             in_valid;
    logic             in_ready;
    logic [CHUNK-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [MSB:LSB]   out_data;
    logic [BW-1:0]    out_bits;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_bits
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_bits
    );
endinterface

// File: rtl/indexed_up_packer.sv
// Packs CHUNK-bit fields into a [MSB:LSB] word at an ascending index,
// emitting the word when full or on flush. Works for either range direction.
module indexed_up_packer #(
    parameter int MSB   = 0,
    parameter int LSB   = 0,
    parameter int CHUNK = 2
) (
    input logic              clk,
    input logic              rst_n,
    indexed_up_packer_if.slave bus
);
    localparam int          LO  = (MSB < LSB) ? MSB : LSB;
    localparam bit          BIG = (MSB < LSB);
    localparam int unsigned N   = (MSB > LSB) ? (MSB - LSB + 1) : (LSB - MSB + 1);
    localparam int unsigned BW  = $clog2(N + 1);
    localparam int unsigned PW  = $clog2(N + CHUNK + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state;
    logic [PW-1:0] ptr;          // offset from LO, so ptr == 0 means index LO
    logic [N-1:0]  word;         // word[p] holds index LO+p
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] out_bits;

    logic [N-1:0]  wr_word;
    logic [PW-1:0] ptr_add;
    logic          fire;
    logic          full;
    logic [BW-1:0] hold_bits;

    // Per-position write: only the bits addressed by the current field change,
    // and indices past the top of the word simply have no position to land in.
    for (genvar p = 0; p < int'(N); p++) begin : g_pos
        logic [CHUNK-1:0] hit;
        logic [CHUNK-1:0] src;
        for (genvar k = 0; k < CHUNK; k++) begin : g_bit
            assign hit[k] = (32'(ptr) + 32'(k) == 32'(p));
            assign src[k] = bus.in_data[BIG ? (CHUNK - 1 - k) : k];
        end
        assign wr_word[p] = (|hit) ? (|(hit & src)) : word[p];
    end

    always_comb begin
        fire      = (state == FILL) && bus.in_valid && in_ready;
        ptr_add   = ptr + PW'(CHUNK);
        full      = (32'(ptr) + 32'(CHUNK)) >= N;
        hold_bits = fire ? (full ? BW'(N) : BW'(ptr_add)) : BW'(ptr);
    end

    // Single-process FSM; a word is emitted when full or flushed non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            ptr       <= '0;
            word      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_bits  <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (fire) begin
                        word <= wr_word;
                        ptr  <= ptr_add;
                    end
                    if ((fire && full) || (bus.flush && ((ptr != '0) || fire))) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_bits  <= hold_bits;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state     <= FILL;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_bits  <= '0;
                        word      <= '0;
                        ptr       <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bits  = out_bits;

    for (genvar gi = 0; gi < int'(N); gi++) begin : g_out
        assign bus.out_data[LO + gi] = word[gi];
    end
endmodule
